// File: rtl/mem_access_stage.sv
// MEM stage controller: branch resolution, req/ack data-memory sequencing and MEM/WB qualification.
// Optional build macro MEM_TIMEOUT_EN adds a BUSY watchdog that aborts an unacknowledged access.
module mem_access_stage #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              regwrite_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic [1:0]        mem_to_reg_in,
   input  logic              branch_in,
   input  logic              zero_flag_in,
   input  logic [31:0]       alu_result_in,
   input  logic [31:0]       branch_target_in,
   input  logic [31:0]       write_data_in,
   input  logic [4:0]        rd_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic              mem_stall,
   output logic              pc_src,
   output logic [31:0]       pc_target,
   output logic              mem_misaligned,
   output logic              mem_fault,
   output logic              wb_regwrite,
   output logic [1:0]        wb_mem_to_reg,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_alu_result,
   output logic [31:0]       wb_load_data
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t state, state_nxt;
   logic   access, misaligned, issue, timeout;

   assign access     = mem_read_in | mem_write_in;
   assign misaligned = access & (alu_result_in[1:0] != 2'b00);
   assign issue      = (state == S_IDLE) & access & ~misaligned;

`ifdef MEM_TIMEOUT_EN
   logic [31:0] tmo_cnt;

   assign timeout = (state == S_BUSY) & ~dmem_ack & (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         tmo_cnt <= '0;
      else if (issue)
         tmo_cnt <= '0;
      else if (state == S_BUSY)
         tmo_cnt <= tmo_cnt + 32'd1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_stall = issue | (state == S_BUSY);
      case (state)
         S_IDLE:  if (issue) state_nxt = S_BUSY;
         S_BUSY:  if (dmem_ack || timeout) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request fields are only loaded on issue, so they stay stable through BUSY.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= '0;
         dmem_wdata     <= '0;
         wb_load_data   <= '0;
         mem_misaligned <= 1'b0;
         mem_fault      <= 1'b0;
      end else begin
         mem_misaligned <= (state == S_IDLE) & misaligned;
         mem_fault      <= timeout;
         if (issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_in;
            dmem_addr  <= alu_result_in[ADDR_W-1:0];
            dmem_wdata <= write_data_in;
         end else if (state == S_BUSY) begin
            if (dmem_ack) begin
               dmem_req <= 1'b0;
               if (!dmem_we)
                  wb_load_data <= dmem_rdata;
            end else if (timeout) begin
               dmem_req     <= 1'b0;
               wb_load_data <= 32'hDEAD_BEEF;
            end
         end
      end
   end

   // mem_fault is high exactly in the DONE cycle following an abort.
   assign wb_regwrite   = regwrite_in & ~mem_stall & ~misaligned & ~mem_fault;
   assign wb_mem_to_reg = mem_to_reg_in;
   assign wb_rd         = rd_in;
   assign wb_alu_result = alu_result_in;
   assign pc_src        = branch_in & zero_flag_in & ~mem_stall;
   assign pc_target     = branch_target_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: load, store, misalignment, branch, async reset, timeout.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        regwrite_in, mem_read_in, mem_write_in, branch_in, zero_flag_in;
   logic [1:0]  mem_to_reg_in;
   logic [31:0] alu_result_in, branch_target_in, write_data_in, dmem_rdata;
   logic [4:0]  rd_in;
   logic        dmem_ack;
   logic        dmem_req, dmem_we, mem_stall, pc_src, mem_misaligned, mem_fault, wb_regwrite;
   logic [31:0] dmem_addr, dmem_wdata, pc_target, wb_alu_result, wb_load_data;
   logic [1:0]  wb_mem_to_reg;
   logic [4:0]  wb_rd;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .regwrite_in(regwrite_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .mem_to_reg_in(mem_to_reg_in), .branch_in(branch_in), .zero_flag_in(zero_flag_in),
      .alu_result_in(alu_result_in), .branch_target_in(branch_target_in),
      .write_data_in(write_data_in), .rd_in(rd_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .mem_stall(mem_stall), .pc_src(pc_src), .pc_target(pc_target),
      .mem_misaligned(mem_misaligned), .mem_fault(mem_fault),
      .wb_regwrite(wb_regwrite), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
      .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      regwrite_in = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;
      branch_in = 0; zero_flag_in = 0; alu_result_in = 0; branch_target_in = 0;
      write_data_in = 0; rd_in = 0;
   endtask

   initial begin
      reset_n = 0; dmem_ack = 0; dmem_rdata = 0;
      clear_inputs();
      #12;
      chk("rst_req",   32'(dmem_req), 32'd0);
      chk("rst_addr",  dmem_addr, 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
      chk("rst_ld",    wb_load_data, 32'd0);
      chk("rst_mis",   32'(mem_misaligned), 32'd0);
      chk("rst_fault", 32'(mem_fault), 32'd0);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      step();
      reset_n = 1;
      step();

      // Load at 0x100, ack in the second BUSY cycle
      mem_read_in = 1; regwrite_in = 1; mem_to_reg_in = 2'd1; alu_result_in = 32'h100; rd_in = 5'd5;
      branch_in = 1; zero_flag_in = 1; branch_target_in = 32'h80;
      #1;
      chk("ld_stall0", 32'(mem_stall), 32'd1);
      chk("ld_wbreg0", 32'(wb_regwrite), 32'd0);
      chk("ld_req0",   32'(dmem_req), 32'd0);
      chk("ld_pcsrc",  32'(pc_src), 32'd0);
      step();
      chk("ld_req1",   32'(dmem_req), 32'd1);
      chk("ld_we1",    32'(dmem_we), 32'd0);
      chk("ld_addr1",  dmem_addr, 32'h100);
      chk("ld_stall1", 32'(mem_stall), 32'd1);
      step();
      dmem_ack = 1; dmem_rdata = 32'h1234_5678;
      #1;
      chk("ld_stall2", 32'(mem_stall), 32'd1);
      chk("ld_req2",   32'(dmem_req), 32'd1);
      step();
      dmem_ack = 0; dmem_rdata = 32'h0;
      chk("ld_done_stall", 32'(mem_stall), 32'd0);
      chk("ld_done_req",   32'(dmem_req), 32'd0);
      chk("ld_data",       wb_load_data, 32'h1234_5678);
      chk("ld_wbreg",      32'(wb_regwrite), 32'd1);
      chk("ld_rd",         32'(wb_rd), 32'd5);
      chk("ld_m2r",        32'(wb_mem_to_reg), 32'd1);
      chk("ld_alu",        wb_alu_result, 32'h100);
      chk("ld_done_pc",    32'(pc_src), 32'd1);
      step();

      // Store back-to-back, ack in the first BUSY cycle; read data must be ignored
      clear_inputs();
      mem_write_in = 1; regwrite_in = 1; alu_result_in = 32'h104; write_data_in = 32'hCAFE_F00D;
      #1;
      chk("st_stall0", 32'(mem_stall), 32'd1);
      chk("st_wbreg0", 32'(wb_regwrite), 32'd0);
      step();
      dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
      #1;
      chk("st_req1",   32'(dmem_req), 32'd1);
      chk("st_we1",    32'(dmem_we), 32'd1);
      chk("st_addr1",  dmem_addr, 32'h104);
      chk("st_wdata1", dmem_wdata, 32'hCAFE_F00D);
      chk("st_wbreg1", 32'(wb_regwrite), 32'd0);
      step();
      dmem_ack = 0; dmem_rdata = 32'h0;
      chk("st_done_req",   32'(dmem_req), 32'd0);
      chk("st_done_stall", 32'(mem_stall), 32'd0);
      chk("st_ld_kept",    wb_load_data, 32'h1234_5678);
      step();

      // Misaligned load
      clear_inputs();
      mem_read_in = 1; regwrite_in = 1; alu_result_in = 32'h102;
      #1;
      chk("mis_stall", 32'(mem_stall), 32'd0);
      chk("mis_wbreg", 32'(wb_regwrite), 32'd0);
      step();
      clear_inputs();
      #1;
      chk("mis_pulse", 32'(mem_misaligned), 32'd1);
      chk("mis_req",   32'(dmem_req), 32'd0);
      step();
      chk("mis_pulse_end", 32'(mem_misaligned), 32'd0);
      chk("mis_req2",      32'(dmem_req), 32'd0);

      // Branch resolution without memory access
      branch_in = 1; zero_flag_in = 1; branch_target_in = 32'h40;
      #1;
      chk("br_pcsrc",  32'(pc_src), 32'd1);
      chk("br_target", pc_target, 32'h40);
      chk("br_stall",  32'(mem_stall), 32'd0);
      zero_flag_in = 0;
      #1;
      chk("br_nz_pcsrc", 32'(pc_src), 32'd0);
      step();

      // Asynchronous reset while BUSY, then a stray ack
      clear_inputs();
      mem_read_in = 1; regwrite_in = 1; alu_result_in = 32'h200;
      step();
      chk("rb_req", 32'(dmem_req), 32'd1);
      #2;
      reset_n = 0;
      clear_inputs();
      #1;
      chk("rb_req_drop", 32'(dmem_req), 32'd0);
      chk("rb_stall",    32'(mem_stall), 32'd0);
      chk("rb_ld_clr",   wb_load_data, 32'd0);
      step();
      reset_n = 1;
      step();
      dmem_ack = 1; dmem_rdata = 32'hA5A5_A5A5;
      #1;
      chk("rb_ack_stall", 32'(mem_stall), 32'd0);
      step();
      dmem_ack = 0; dmem_rdata = 32'h0;
      chk("rb_ack_req",  32'(dmem_req), 32'd0);
      chk("rb_ack_ld",   wb_load_data, 32'd0);
      chk("rb_ack_stl2", 32'(mem_stall), 32'd0);

      // Load with no ack
      mem_read_in = 1; regwrite_in = 1; alu_result_in = 32'h300;
      step();
      step();
      step();
      step();
      chk("to_busy4_stall", 32'(mem_stall), 32'd1);
      chk("to_busy4_fault", 32'(mem_fault), 32'd0);
      chk("to_busy4_req",   32'(dmem_req), 32'd1);
      step();
`ifdef MEM_TIMEOUT_EN
      chk("to_fault",   32'(mem_fault), 32'd1);
      chk("to_req",     32'(dmem_req), 32'd0);
      chk("to_ld",      wb_load_data, 32'hDEAD_BEEF);
      chk("to_wbreg",   32'(wb_regwrite), 32'd0);
      chk("to_stall",   32'(mem_stall), 32'd0);
      step();
      clear_inputs();
      #1;
      chk("to_fault_end", 32'(mem_fault), 32'd0);
      chk("to_resume",    32'(mem_stall), 32'd0);
`else
      chk("nto_fault", 32'(mem_fault), 32'd0);
      chk("nto_req",   32'(dmem_req), 32'd1);
      chk("nto_stall", 32'(mem_stall), 32'd1);
      dmem_ack = 1; dmem_rdata = 32'h0BAD_F00D;
      step();
      dmem_ack = 0;
      chk("nto_ld",    wb_load_data, 32'h0BAD_F00D);
      chk("nto_wbreg", 32'(wb_regwrite), 32'd1);
      step();
      clear_inputs();
      #1;
      chk("nto_resume", 32'(mem_stall), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
